// File: rtl/coin_payout_pkg.sv
// Shared definitions for the coin payout block: denomination encoding and values,
// controller state encoding and default limits.
package coin_payout_pkg;

  localparam int AMT_W_DEF   = 14;
  localparam int MAX_AMT_DEF = 9999;
  localparam int TMR_W       = 16;

  typedef enum logic [1:0] {
    SEL_1   = 2'd0,
    SEL_10  = 2'd1,
    SEL_50  = 2'd2,
    SEL_100 = 2'd3
  } coin_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_GAP,
    ST_DONE,
    ST_FAULT
  } state_e;

  function automatic logic [6:0] coin_value(input coin_sel_e sel);
    case (sel)
      SEL_100: return 7'd100;
      SEL_50:  return 7'd50;
      SEL_10:  return 7'd10;
      default: return 7'd1;
    endcase
  endfunction

endpackage

// File: rtl/coin_payout_if.sv
// Coin-dispense handshake between the payout controller and the hopper driver.
interface coin_payout_if;

  logic       coin_valid;
  logic [1:0] coin_sel;
  logic       coin_ack;

  modport master (output coin_valid, output coin_sel, input coin_ack);
  modport slave  (input coin_valid, input coin_sel, output coin_ack);

endinterface

// File: rtl/coin_payout_timer.sv
// Loadable down-counter with a zero flag; used for the inter-coin gap and the ack timeout.
module payout_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)                      cnt <= '0;
    else if (load)                cnt <= load_val;
    else if (dec && cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/coin_payout.sv
// Payout controller: turns a credit amount into a greedy 100/50/10/1 coin sequence on the
// hopper handshake and debits the bank once per transferred coin.
module coin_payout
  import coin_payout_pkg::*;
#(
  parameter int AMT_W       = AMT_W_DEF,
  parameter int MAX_AMT     = MAX_AMT_DEF,
  parameter int GAP_CYC     = 4,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             payout_req,
  input  logic [AMT_W-1:0] payout_amt,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             fault,
  coin_payout_if.master    hop,
  output logic             debit_pulse,
  output logic [6:0]       debit_amt,
  output logic [AMT_W-1:0] remaining
);

  localparam logic [TMR_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? TMR_W'(GAP_CYC - 1) : '0;
  localparam logic [TMR_W-1:0] ACK_LOAD = TMR_W'(ACK_TIMEOUT - 1);

  state_e           state;
  coin_sel_e        coin_sel_q;
  coin_sel_e        sel_c;
  logic             coin_valid_q;
  logic [6:0]       val_c;
  logic [AMT_W-1:0] rem_after;
  logic             xfer;
  logic             gap_zero;
  logic             ack_zero;

  assign hop.coin_valid = coin_valid_q;
  assign hop.coin_sel   = coin_sel_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sel_c = SEL_1;
    if (remaining >= AMT_W'(100))     sel_c = SEL_100;
    else if (remaining >= AMT_W'(50)) sel_c = SEL_50;
    else if (remaining >= AMT_W'(10)) sel_c = SEL_10;
  end

  // Selection guarantees the issued coin never exceeds remaining, so rem_after cannot wrap.
  assign val_c     = coin_value(coin_sel_q);
  assign rem_after = remaining - AMT_W'(val_c);
  assign xfer      = (state == ST_ISSUE) && coin_valid_q && hop.coin_ack;

  payout_timer #(.W(TMR_W)) u_gap_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (xfer && (rem_after != '0)),
    .load_val (GAP_LOAD),
    .dec      (state == ST_GAP),
    .zero     (gap_zero)
  );

  payout_timer #(.W(TMR_W)) u_ack_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_SELECT),
    .load_val (ACK_LOAD),
    .dec      ((state == ST_ISSUE) && !xfer),
    .zero     (ack_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      fault        <= 1'b0;
      coin_valid_q <= 1'b0;
      coin_sel_q   <= SEL_1;
      debit_pulse  <= 1'b0;
      debit_amt    <= '0;
      remaining    <= '0;
    end else begin
      done        <= 1'b0;
      err         <= 1'b0;
      debit_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (payout_req) begin
            if (payout_amt > AMT_W'(MAX_AMT)) begin
              err <= 1'b1;
            end else if (payout_amt == '0) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              remaining <= payout_amt;
              busy      <= 1'b1;
              state     <= ST_SELECT;
            end
          end
        end
        ST_SELECT: begin
          coin_sel_q   <= sel_c;
          coin_valid_q <= 1'b1;
          state        <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (xfer) begin
            coin_valid_q <= 1'b0;
            remaining    <= rem_after;
            debit_pulse  <= 1'b1;
            debit_amt    <= val_c;
            if (rem_after == '0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end else if (GAP_CYC == 0) begin
              state <= ST_SELECT;
            end else begin
              state <= ST_GAP;
            end
          end else if (ack_zero) begin
            // Hopper never answered: freeze the remaining amount and park until reset.
            coin_valid_q <= 1'b0;
            fault        <= 1'b1;
            busy         <= 1'b0;
            state        <= ST_FAULT;
          end
        end
        ST_GAP: begin
          if (gap_zero) state <= ST_SELECT;
        end
        ST_DONE:  state <= ST_IDLE;
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_payout.sv
// Self-checking bench for coin_payout: greedy-change model, randomized payouts and ack delays,
// plus directed latency, gap, reject, timeout and reset scenarios.
module tb_coin_payout;

  localparam int AMT_W       = 14;
  localparam int MAX_AMT     = 9999;
  localparam int GAP_CYC     = 4;
  localparam int ACK_TIMEOUT = 1000;

  logic             clk = 1'b0;
  logic             rst;
  logic             payout_req;
  logic [AMT_W-1:0] payout_amt;
  logic             busy, done, err, fault, debit_pulse;
  logic [6:0]       debit_amt;
  logic [AMT_W-1:0] remaining;

  coin_payout_if hif();

  coin_payout #(
    .AMT_W(AMT_W), .MAX_AMT(MAX_AMT), .GAP_CYC(GAP_CYC), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .payout_req  (payout_req),
    .payout_amt  (payout_amt),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .fault       (fault),
    .hop         (hif.master),
    .debit_pulse (debit_pulse),
    .debit_amt   (debit_amt),
    .remaining   (remaining)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected coin list from the greedy change rule, owned by one process.
  int m_rem = 0;
  int m_q[$];
  bit m_busy = 0;
  bit pend = 0;
  int pend_amt = 0;
  int done_cnt = 0, debit_cnt = 0, debit_sum = 0;
  int seen_amt[$], seen_sel[$], seen_rem[$];

  function automatic int sel_value(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return 10;
      2'd2:    return 50;
      default: return 100;
    endcase
  endfunction

  function automatic int coin_count(input int a);
    return a / 100 + (a % 100) / 50 + (a % 50) / 10 + a % 10;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      m_rem = 0; m_q.delete(); m_busy = 0; pend = 0;
    end else begin
      if (pend) begin
        pend = 0;
        if (pend_amt != 0 && pend_amt <= MAX_AMT) begin
          m_rem = pend_amt;
          m_q.delete();
          repeat (pend_amt / 100)        m_q.push_back(100);
          repeat ((pend_amt % 100) / 50) m_q.push_back(50);
          repeat ((pend_amt % 50) / 10)  m_q.push_back(10);
          repeat (pend_amt % 10)         m_q.push_back(1);
          m_busy = 1;
        end
      end
      if (debit_pulse) begin
        debit_cnt++;
        debit_sum += int'(debit_amt);
        seen_amt.push_back(int'(debit_amt));
        seen_sel.push_back(int'(hif.coin_sel));
        seen_rem.push_back(int'(remaining));
        if (m_q.size() == 0) check("unexpected_debit", debit_pulse, 1'b0);
        else begin
          check("debit_amt", debit_amt, m_q[0]);
          m_rem -= m_q[0];
          void'(m_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        check("done_with_coins_left", m_q.size(), 0);
        m_busy = 0;
      end
      check("remaining", remaining, m_rem);
      check("busy", busy, m_busy && !fault);
      if (hif.coin_valid) begin
        if (m_q.size() == 0) check("unexpected_valid", hif.coin_valid, 1'b0);
        else                 check("coin_sel", sel_value(hif.coin_sel), m_q[0]);
      end
      if (fault) check("valid_in_fault", hif.coin_valid, 1'b0);
      if (payout_req && !m_busy && !done && !fault) begin
        pend = 1;
        pend_amt = int'(payout_amt);
      end
    end
  end

  // Hopper model: acks after a random number of valid cycles; optional stray acks while idle.
  int max_delay = 0;
  bit ack_hold = 0;
  bit spurious = 0;

  initial begin
    int wait_cnt = 0;
    int cur_delay = 0;
    hif.coin_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (hif.coin_ack) hif.coin_ack = 1'b0;
      else if (hif.coin_valid && !ack_hold) begin
        if (wait_cnt >= cur_delay) begin
          hif.coin_ack = 1'b1;
          wait_cnt = 0;
          cur_delay = int'($urandom_range(0, max_delay));
        end else wait_cnt++;
      end else if (!hif.coin_valid && spurious && $urandom_range(0, 7) == 0) begin
        hif.coin_ack = 1'b1;
      end
    end
  end

  task automatic start(input int amt);
    @(posedge clk); #1;
    payout_req = 1'b1;
    payout_amt = AMT_W'(amt);
    @(posedge clk); #1;
    payout_req = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string name);
    int n = 0;
    while (done_cnt == d0 && !fault && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, done_cnt - d0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0, b0, s0, i0, n, low, hc;
    bit busy_seen, valid_seen;
    int e_amt[4] = '{100, 50, 10, 1};
    int e_sel[4] = '{3, 2, 1, 0};
    int e_rem[4] = '{61, 11, 1, 0};

    rst = 1'b1; payout_req = 1'b0; payout_amt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);       check("rst_done", done, 0);
    check("rst_err", err, 0);         check("rst_fault", fault, 0);
    check("rst_valid", hif.coin_valid, 0); check("rst_sel", hif.coin_sel, 0);
    check("rst_debit", debit_pulse, 0);    check("rst_remaining", remaining, 0);
    rst = 1'b0;

    // 161: latency, then 100/50/10/1 with literal expectations
    d0 = done_cnt; b0 = debit_cnt; i0 = seen_amt.size();
    start(161);
    @(negedge clk); check("lat_select_low", hif.coin_valid, 0);
    @(negedge clk); check("lat_valid_high", hif.coin_valid, 1);
    wait_done(d0, 200, "p161_done");
    repeat (3) @(posedge clk);
    check("p161_done_count", done_cnt - d0, 1);
    check("p161_debits", debit_cnt - b0, 4);
    for (int k = 0; k < 4; k++) begin
      if (i0 + k < seen_amt.size()) begin
        check("p161_amt", seen_amt[i0 + k], e_amt[k]);
        check("p161_sel", seen_sel[i0 + k], e_sel[k]);
        check("p161_rem", seen_rem[i0 + k], e_rem[k]);
      end else check("p161_missing_debit", seen_amt.size(), i0 + 4);
    end

    // zero amount: immediate done, no coins, never busy
    d0 = done_cnt; busy_seen = 0; valid_seen = 0;
    start(0);
    repeat (4) begin
      @(negedge clk);
      busy_seen |= busy; valid_seen |= hif.coin_valid;
    end
    @(posedge clk);
    check("zero_done", done_cnt - d0, 1);
    check("zero_busy", busy_seen, 0);
    check("zero_valid", valid_seen, 0);

    // over-limit reject, then a 1-unit payout proves IDLE was kept
    d0 = done_cnt;
    start(10000);
    @(negedge clk); check("err_pulse", err, 1); check("err_busy", busy, 0);
    @(negedge clk); check("err_one_cycle", err, 0);
    s0 = debit_sum;
    start(1);
    wait_done(d0, 50, "after_err_done");
    check("after_err_sum", debit_sum - s0, 1);
    check("err_no_done", done_cnt - d0, 1);

    // 20: gap length between transfer and next offer; stray request while busy
    d0 = done_cnt; s0 = debit_sum;
    start(20);
    fork
      begin
        n = 0;
        @(negedge clk);
        while (!debit_pulse && n < 50) begin @(negedge clk); n++; end
        low = 0;
        while (!hif.coin_valid && low < 50) begin low++; @(negedge clk); end
        check("gap_low_cycles", low, GAP_CYC + 1);
      end
      begin
        repeat (2) @(posedge clk);
        start(500);
      end
    join
    wait_done(d0, 100, "p20_done");
    check("p20_sum", debit_sum - s0, 20);

    // 300: hopper stops answering on the third coin -> fault
    d0 = done_cnt; b0 = debit_cnt;
    start(300);
    n = 0;
    while (debit_cnt - b0 < 2 && n < 200) begin @(posedge clk); n++; end
    ack_hold = 1;
    n = 0;
    @(negedge clk);
    while (!hif.coin_valid && n < 100) begin @(negedge clk); n++; end
    hc = 0;
    while (hif.coin_valid && hc < ACK_TIMEOUT + 200) begin hc++; @(negedge clk); end
    check("timeout_valid_cycles", hc, ACK_TIMEOUT);
    check("fault_set", fault, 1);
    check("fault_remaining", remaining, 100);
    check("fault_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("fault_held", fault, 1);
    @(posedge clk);
    check("fault_debits", debit_cnt - b0, 2);
    check("fault_no_done", done_cnt - d0, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("fault_cleared", fault, 0);
    rst = 1'b0;
    ack_hold = 0;

    // 75: reset while a coin is offered aborts cleanly
    ack_hold = 1;
    start(75);
    n = 0;
    @(negedge clk);
    while (!hif.coin_valid && n < 20) begin @(negedge clk); n++; end
    check("abort_valid_seen", hif.coin_valid, 1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_valid", hif.coin_valid, 0);
    check("abort_remaining", remaining, 0);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    ack_hold = 0;
    d0 = done_cnt; b0 = debit_cnt;
    repeat (20) @(posedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_debit", debit_cnt - b0, 0);

    // randomized payouts, first one at the legal maximum
    spurious = 1;
    for (int t = 0; t < 12; t++) begin
      int amt;
      amt = (t == 0) ? MAX_AMT : int'($urandom_range(1, MAX_AMT));
      max_delay = int'($urandom_range(0, 4));
      d0 = done_cnt; b0 = debit_cnt; s0 = debit_sum;
      start(amt);
      wait_done(d0, coin_count(amt) * (GAP_CYC + max_delay + 6) + 50, "rand_done");
      check("rand_sum", debit_sum - s0, amt);
      check("rand_count", debit_cnt - b0, coin_count(amt));
      repeat (2) @(posedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
